sdram_line_reader: RTL and testbench
====================================

# sdram_line_reader

Avalon-MM burst-read master that fetches one display line of 16-bit pixels from SDRAM and streams them out with valid/ready flow control. It sits directly upstream of the SDRAM subsystem's Avalon slave port and downstream of the frame/line sequencer that issues `start`. It feeds the pixel/scanout pipeline. An internal credit-checked FIFO guarantees that read data returned by SDRAM is never dropped.

## Interface
- `ADDR_W`, 25: word address width; 13 row + 2 bank + 10 column bits.
- `DATA_W`, 16: pixel and SDRAM word width.
- `LINE_WORDS`, 640: words fetched per `start`; range 1..4095.
- `BURST_LEN`, 8: maximum Avalon burst length; power of 2, at most `FIFO_DEPTH`.
- `FIFO_DEPTH`, 32: internal FIFO entries; power of 2.
- `clk_clk`  in  1  single clock for all logic.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to fetch a line; sampled only in IDLE.
- `base_addr`  in  ADDR_W  word address of the first pixel; sampled with `start`.
- `busy`  out  1  high while a line is in progress.
- `done`  out  1  one-cycle pulse when the last pixel of the line is accepted downstream.
- `avm_address`  out  ADDR_W  word address of the burst.
- `avm_read`  out  1  read request.
- `avm_burstcount`  out  clog2(BURST_LEN)+1  words in the burst.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  DATA_W  returned word.
- `avm_readdatavalid`  in  1  qualifies `avm_readdata`.
- `px_data`  out  DATA_W  pixel output.
- `px_valid`  out  1  `px_data` valid.
- `px_ready`  in  1  downstream accepts the word.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: on `start`, latch `base_addr` into `next_addr`, set `words_to_req`=LINE_WORDS and `words_to_pop`=LINE_WORDS, go to ISSUE.
- ISSUE: while `avm_read` is low, assert `avm_read` when `free` ≥ `blen`.
  - `free` = FIFO_DEPTH − `fifo_count` − `outstanding`.
  - `blen` = min(BURST_LEN, `words_to_req`).
  - Drive `avm_address`=`next_addr` and `avm_burstcount`=`blen`.
- Burst acceptance happens when `avm_read` is high and `avm_waitrequest` is low. On acceptance:
  - `next_addr` += `blen`, wrapping modulo 2^ADDR_W.
  - `words_to_req` −= `blen`.
  - `outstanding` += `blen`.
  - `avm_read` drops.
  - If `words_to_req` becomes 0, go to DRAIN.
- On each `avm_readdatavalid`: push `avm_readdata` into the FIFO and decrement `outstanding`.
- Pop occurs when `px_valid` and `px_ready` are both high. On pop, decrement `words_to_pop`. When it reaches 0, pulse `done` and return to IDLE.
- Simultaneous push, pop, and burst acceptance in one cycle: all counters update net-correctly in that same cycle.
- FIFO overflow is impossible by construction; the credit check reserves space before issuing.
- `start` is ignored while `busy`=1.
- `busy` = (state ≠ IDLE). It falls in the same cycle `done` pulses.
- Reset mid-line: everything returns to IDLE and the FIFO empties. The SDRAM subsystem shares this reset, so no stale `readdatavalid` is expected afterward.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `avm_read`=0, `px_valid`=0.
  - `avm_address`=0, `avm_burstcount`=0, `px_data`=0.
- `start` at cycle N: `busy` and `avm_read` are high at N+1.
- While `avm_waitrequest`=1, `avm_address`, `avm_burstcount` and `avm_read` hold stable.
- The cycle after a burst is accepted, `avm_read` is low. The next burst may assert one cycle later, so bursts are spaced by at least one idle cycle.
- A word with `avm_readdatavalid` at cycle M appears on `px_data`/`px_valid` at M+1 if the FIFO was empty.
- Sustained throughput is one pixel per cycle when `px_ready`=1, apart from request spacing.
- `done` is asserted in the cycle after the final pop handshake. `start` is accepted from the following cycle.

## Test plan
- Reset: hold `reset_reset_n`=0 with random inputs → all outputs 0. Deassert → outputs stay idle with no `avm_read`.
- LINE_WORDS=20, BURST_LEN=8, `base_addr`=0x00100, zero-wait slave, `px_ready`=1 → three bursts: 0x00100/8, 0x00108/8, 0x00110/4. All 20 words emerge in order, then exactly one `done` pulse. `busy` is high for the entire span.
- Backpressure: `px_ready`=0, LINE_WORDS=640 → exactly FIFO_DEPTH (32) words requested, then no further `avm_read`. Release `px_ready` → fetching resumes. All 640 words are delivered with no loss.
- `avm_waitrequest` held high for 5 cycles on the second burst → address and burstcount are stable across all 5 cycles. The burst is accepted once, on the first low cycle.
- `base_addr`=0x1FFFFFC, LINE_WORDS=8, BURST_LEN=4 → bursts at 0x1FFFFFC and 0x0000000, demonstrating address wrap.
- `start` pulsed mid-line is ignored. Reset asserted mid-line → idle outputs. A new `start` afterward fetches a clean line from the new base.

Source files
------------

// File: rtl/sdram_line_reader.sv
// Avalon-MM burst-read master: fetches one line of pixels from SDRAM into a
// credit-checked FIFO and streams them out with valid/ready handshaking.
module sdram_line_reader #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_WORDS = 640,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 32,
    localparam int unsigned BC_W      = $clog2(BURST_LEN) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [BC_W-1:0]   avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned WCNT_W = 13;
    localparam logic [BC_W-1:0] FIRST_BLEN =
        BC_W'((LINE_WORDS < BURST_LEN) ? LINE_WORDS : BURST_LEN);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [BC_W-1:0]     burstcount_q, burstcount_d;
    logic                read_q, read_d;
    logic                done_q, done_d;
    logic [WCNT_W-1:0]   words_to_req_q, words_to_req_d;
    logic [WCNT_W-1:0]   words_to_pop_q, words_to_pop_d;
    logic [FCNT_W-1:0]   outstanding_q, outstanding_d;
    logic [FCNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];

    logic                push, pop, accept;
    logic [FCNT_W-1:0]   free;
    logic [BC_W-1:0]     blen;

    assign push   = avm_readdatavalid;
    assign pop    = px_valid & px_ready;
    assign accept = read_q & ~avm_waitrequest;
    // Space not yet claimed by stored words or by words still in flight.
    assign free   = FCNT_W'(FIFO_DEPTH) - fifo_count_q - outstanding_q;
    assign blen   = (words_to_req_q >= WCNT_W'(BURST_LEN)) ? BC_W'(BURST_LEN)
                                                           : words_to_req_q[BC_W-1:0];

    always_comb begin
        state_d        = state_q;
        next_addr_d    = next_addr_q;
        address_d      = address_q;
        burstcount_d   = burstcount_q;
        read_d         = read_q;
        done_d         = 1'b0;
        words_to_req_d = words_to_req_q;
        words_to_pop_d = words_to_pop_q;
        outstanding_d  = outstanding_q + (accept ? FCNT_W'(burstcount_q) : '0)
                         - FCNT_W'(push);
        fifo_count_d   = fifo_count_q + FCNT_W'(push) - FCNT_W'(pop);

        if (accept) begin
            next_addr_d    = next_addr_q + ADDR_W'(burstcount_q);
            words_to_req_d = words_to_req_q - WCNT_W'(burstcount_q);
            read_d         = 1'b0;
        end
        if (pop) begin
            words_to_pop_d = words_to_pop_q - WCNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    next_addr_d    = base_addr;
                    words_to_req_d = WCNT_W'(LINE_WORDS);
                    words_to_pop_d = WCNT_W'(LINE_WORDS);
                    read_d         = 1'b1;
                    address_d      = base_addr;
                    burstcount_d   = FIRST_BLEN;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                if (accept && words_to_req_d == '0) begin
                    state_d = StDrain;
                end else if (!read_q && free >= FCNT_W'(blen)) begin
                    read_d       = 1'b1;
                    address_d    = next_addr_q;
                    burstcount_d = blen;
                end
            end
            StDrain: ;
            default: state_d = StIdle;
        endcase

        if (pop && words_to_pop_q == WCNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= StIdle;
            next_addr_q    <= '0;
            address_q      <= '0;
            burstcount_q   <= '0;
            read_q         <= 1'b0;
            done_q         <= 1'b0;
            words_to_req_q <= '0;
            words_to_pop_q <= '0;
            outstanding_q  <= '0;
            fifo_count_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            next_addr_q    <= next_addr_d;
            address_q      <= address_d;
            burstcount_q   <= burstcount_d;
            read_q         <= read_d;
            done_q         <= done_d;
            words_to_req_q <= words_to_req_d;
            words_to_pop_q <= words_to_pop_d;
            outstanding_q  <= outstanding_d;
            fifo_count_q   <= fifo_count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr_q] <= avm_readdata;
    end

    assign px_valid       = (fifo_count_q != '0);
    assign px_data        = px_valid ? mem[rd_ptr_q] : '0;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign avm_read       = read_q;
    assign avm_address    = address_q;
    assign avm_burstcount = burstcount_q;

endmodule

// File: tb/tb_sdram_line_reader.sv
// Directed bench: three reader instances (20/8, 640/8, 8/4 line/burst) behind
// a zero-latency SDRAM model whose read data is the low 16 bits of the address.
module tb_sdram_line_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [3];
    logic [24:0] base [3];
    logic        busy [3];
    logic        done [3];
    logic [24:0] addr [3];
    logic        read [3];
    logic [3:0]  bc [3];
    logic        wr [3];
    logic [15:0] rdata [3];
    logic        rdv [3];
    logic [15:0] pxd [3];
    logic        pxv [3];
    logic        pxr [3];
    logic [3:0]  bc_w0, bc_w1;
    logic [2:0]  bc_w2;

    int tests = 0;
    int fails = 0;

    logic [24:0] burst_addr [$];
    logic [3:0]  burst_len [$];

    logic [24:0] sq [3][1024];
    int          head [3];
    int          tail [3];

    always #5 clk = ~clk;

    assign bc[0] = bc_w0;
    assign bc[1] = bc_w1;
    assign bc[2] = {1'b0, bc_w2};

    sdram_line_reader #(.LINE_WORDS(20), .BURST_LEN(8), .FIFO_DEPTH(32)) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start[0]), .base_addr(base[0]),
        .busy(busy[0]), .done(done[0]), .avm_address(addr[0]), .avm_read(read[0]),
        .avm_burstcount(bc_w0), .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
        .avm_readdatavalid(rdv[0]), .px_data(pxd[0]), .px_valid(pxv[0]), .px_ready(pxr[0])
    );

    sdram_line_reader #(.LINE_WORDS(640), .BURST_LEN(8), .FIFO_DEPTH(32)) dut_c (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start[1]), .base_addr(base[1]),
        .busy(busy[1]), .done(done[1]), .avm_address(addr[1]), .avm_read(read[1]),
        .avm_burstcount(bc_w1), .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
        .avm_readdatavalid(rdv[1]), .px_data(pxd[1]), .px_valid(pxv[1]), .px_ready(pxr[1])
    );

    sdram_line_reader #(.LINE_WORDS(8), .BURST_LEN(4), .FIFO_DEPTH(32)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start[2]), .base_addr(base[2]),
        .busy(busy[2]), .done(done[2]), .avm_address(addr[2]), .avm_read(read[2]),
        .avm_burstcount(bc_w2), .avm_waitrequest(wr[2]), .avm_readdata(rdata[2]),
        .avm_readdatavalid(rdv[2]), .px_data(pxd[2]), .px_valid(pxv[2]), .px_ready(pxr[2])
    );

    // SDRAM model: accepted bursts queue their word addresses; one word returns per cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                rdv[i]   <= 1'b0;
                rdata[i] <= '0;
                head[i]  <= 0;
                tail[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (head[i] != tail[i]) begin
                    rdv[i]   <= 1'b1;
                    rdata[i] <= sq[i][head[i] % 1024][15:0];
                    head[i]  <= head[i] + 1;
                end else begin
                    rdv[i] <= 1'b0;
                end
                if (read[i] && !wr[i]) begin
                    for (int k = 0; k < int'(bc[i]); k++)
                        sq[i][(tail[i] + k) % 1024] <= addr[i] + 25'(k);
                    tail[i] <= tail[i] + int'(bc[i]);
                end
            end
        end
    end

    // Starts a line on instance i and observes it until done (plus a few cycles) or budget.
    task automatic run_line(input int i, input logic [24:0] b, input int max_cyc,
                            input int stall_idx, input int stall_cyc, input int hold_cyc,
                            output int pops, output int bad, output int dones,
                            output int busy_gaps, output int unstable,
                            output int words_at_hold, output logic read_at_hold,
                            output logic first_ok);
        int nb = 0, words = 0, stalled = 0, since_done = 0;
        logic [24:0] st_a = '0;
        logic [3:0]  st_b = '0;
        pops = 0; bad = 0; dones = 0; busy_gaps = 0; unstable = 0;
        words_at_hold = 0; read_at_hold = 1'b0; first_ok = 1'b0;
        burst_addr.delete();
        burst_len.delete();
        @(negedge clk);
        start[i] = 1'b1;
        base[i]  = b;
        pxr[i]   = (hold_cyc > 0) ? 1'b0 : 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start[i] = 1'b0;
            if (c == 1) first_ok = busy[i] && read[i];
            if (c == hold_cyc) begin
                words_at_hold = words;
                read_at_hold  = read[i];
            end
            if (c > hold_cyc) pxr[i] = 1'b1;
            if (read[i] && nb == stall_idx && stalled < stall_cyc) begin
                if (stalled == 0) begin
                    st_a = addr[i];
                    st_b = bc[i];
                end else if (addr[i] !== st_a || bc[i] !== st_b) begin
                    unstable++;
                end
                wr[i] = 1'b1;
                stalled++;
            end else begin
                if (stalled > 0 && nb == stall_idx &&
                    (!read[i] || addr[i] !== st_a || bc[i] !== st_b)) unstable++;
                wr[i] = 1'b0;
            end
            if (read[i] && !wr[i]) begin
                burst_addr.push_back(addr[i]);
                burst_len.push_back(bc[i]);
                nb++;
                words += int'(bc[i]);
            end
            if (pxv[i] && pxr[i]) begin
                if (pxd[i] !== 16'(b + 25'(pops))) bad++;
                pops++;
            end
            if (dones == 0 && !done[i] && !busy[i]) busy_gaps++;
            if (done[i]) dones++;
            if (dones > 0) begin
                since_done++;
                if (since_done > 4) break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start[i] = 1'($urandom);
                base[i]  = 25'($urandom);
                wr[i]    = 1'($urandom);
                pxr[i]   = 1'($urandom);
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                tests++;
                if ({busy[i], done[i], read[i], pxv[i], addr[i], bc[i], pxd[i]} !== '0) begin
                    fails++;
                    $display("FAIL reset_outputs inst%0d: got busy=%b done=%b read=%b pxv=%b addr=%h bc=%h pxd=%h, required all 0",
                             i, busy[i], done[i], read[i], pxv[i], addr[i], bc[i], pxd[i]);
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            wr[i]    = 1'b0;
            pxr[i]   = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({busy[i], read[i], pxv[i]} !== 3'b000) begin
                fails++;
                $display("FAIL post_reset_idle inst%0d: got busy=%b read=%b pxv=%b, required 000",
                         i, busy[i], read[i], pxv[i]);
            end
        end
    endtask

    task automatic test_line20();
        int pops, bad, dones, gaps, unst, wah;
        logic rah, fok;
        logic [28:0] exp_b [3];
        exp_b[0] = {25'h0000100, 4'd8};
        exp_b[1] = {25'h0000108, 4'd8};
        exp_b[2] = {25'h0000110, 4'd4};
        run_line(0, 25'h0000100, 200, -1, 0, 0, pops, bad, dones, gaps, unst, wah, rah, fok);
        tests++;
        if (fok !== 1'b1) begin
            fails++; $display("FAIL line20_start_latency: got busy&read=%b, required 1", fok);
        end
        tests++;
        if (burst_addr.size() != 3) begin
            fails++; $display("FAIL line20_burst_count: got %0d, required 3", burst_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if ({burst_addr[k], burst_len[k]} !== exp_b[k]) begin
                    fails++;
                    $display("FAIL line20_burst%0d: got %h/%0d, required %h/%0d", k,
                             burst_addr[k], burst_len[k], exp_b[k][28:4], exp_b[k][3:0]);
                end
            end
        end
        tests++;
        if (pops != 20 || bad != 0) begin
            fails++; $display("FAIL line20_data: got %0d pops %0d bad, required 20 pops 0 bad", pops, bad);
        end
        tests++;
        if (dones != 1) begin
            fails++; $display("FAIL line20_done: got %0d pulses, required 1", dones);
        end
        tests++;
        if (gaps != 0) begin
            fails++; $display("FAIL line20_busy: got %0d idle cycles mid-line, required 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int pops, bad, dones, gaps, unst, wah, total;
        logic rah, fok;
        run_line(1, 25'h0002000, 5000, -1, 0, 60, pops, bad, dones, gaps, unst, wah, rah, fok);
        tests++;
        if (wah != 32) begin
            fails++; $display("FAIL bp_credit_limit: got %0d words requested, required 32", wah);
        end
        tests++;
        if (rah !== 1'b0) begin
            fails++; $display("FAIL bp_read_stalled: got avm_read=%b, required 0", rah);
        end
        total = 0;
        foreach (burst_len[k]) total += int'(burst_len[k]);
        tests++;
        if (total != 640) begin
            fails++; $display("FAIL bp_total_requested: got %0d, required 640", total);
        end
        tests++;
        if (pops != 640 || bad != 0) begin
            fails++; $display("FAIL bp_data: got %0d pops %0d bad, required 640 pops 0 bad", pops, bad);
        end
        tests++;
        if (dones != 1) begin
            fails++; $display("FAIL bp_done: got %0d pulses, required 1", dones);
        end
    endtask

    task automatic test_waitrequest();
        int pops, bad, dones, gaps, unst, wah;
        logic rah, fok;
        run_line(0, 25'h0003000, 300, 1, 5, 0, pops, bad, dones, gaps, unst, wah, rah, fok);
        tests++;
        if (unst != 0) begin
            fails++; $display("FAIL wait_stable: got %0d unstable cycles, required 0", unst);
        end
        tests++;
        if (burst_addr.size() != 3) begin
            fails++; $display("FAIL wait_burst_count: got %0d, required 3", burst_addr.size());
        end else begin
            tests++;
            if ({burst_addr[1], burst_len[1]} !== {25'h0003008, 4'd8}) begin
                fails++;
                $display("FAIL wait_burst1: got %h/%0d, required 0003008/8", burst_addr[1], burst_len[1]);
            end
        end
        tests++;
        if (pops != 20 || bad != 0 || dones != 1) begin
            fails++;
            $display("FAIL wait_data: got %0d pops %0d bad %0d done, required 20 0 1", pops, bad, dones);
        end
    endtask

    task automatic test_wrap();
        int pops, bad, dones, gaps, unst, wah;
        logic rah, fok;
        run_line(2, 25'h1FFFFFC, 100, -1, 0, 0, pops, bad, dones, gaps, unst, wah, rah, fok);
        tests++;
        if (burst_addr.size() != 2) begin
            fails++; $display("FAIL wrap_burst_count: got %0d, required 2", burst_addr.size());
        end else begin
            tests++;
            if ({burst_addr[0], burst_len[0], burst_addr[1], burst_len[1]} !==
                {25'h1FFFFFC, 4'd4, 25'h0000000, 4'd4}) begin
                fails++;
                $display("FAIL wrap_bursts: got %h/%0d %h/%0d, required 1fffffc/4 0000000/4",
                         burst_addr[0], burst_len[0], burst_addr[1], burst_len[1]);
            end
        end
        tests++;
        if (pops != 8 || bad != 0 || dones != 1) begin
            fails++;
            $display("FAIL wrap_data: got %0d pops %0d bad %0d done, required 8 0 1", pops, bad, dones);
        end
    endtask

    task automatic test_midline();
        int pops = 0, bad = 0, dones, gaps, unst, wah;
        logic rah, fok;
        burst_addr.delete();
        burst_len.delete();
        @(negedge clk);
        start[0] = 1'b1;
        base[0]  = 25'h0004000;
        pxr[0]   = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start[0] = (c == 6);
            if (c == 6) base[0] = 25'h0005000;
            if (read[0] && !wr[0]) begin
                burst_addr.push_back(addr[0]);
                burst_len.push_back(bc[0]);
            end
            if (pxv[0] && pxr[0]) begin
                if (pxd[0] !== 16'(25'h0004000 + 25'(pops))) bad++;
                pops++;
            end
        end
        tests++;
        if (burst_addr.size() != 3 || burst_addr[2] !== 25'h0004010) begin
            fails++;
            $display("FAIL mid_start_ignored: got %0d bursts last %h, required 3 last 0004010",
                     burst_addr.size(), burst_addr.size() > 0 ? burst_addr[burst_addr.size()-1] : '0);
        end
        tests++;
        if (busy[0] !== 1'b1 || bad != 0 || pops == 0 || pops >= 20) begin
            fails++;
            $display("FAIL mid_in_progress: got busy=%b pops=%0d bad=%0d, required busy=1 pops 1..19 bad 0",
                     busy[0], pops, bad);
        end
        @(negedge clk);
        start[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy[0], done[0], read[0], pxv[0], addr[0], bc[0], pxd[0]} !== '0) begin
            fails++;
            $display("FAIL mid_reset_idle: got busy=%b done=%b read=%b pxv=%b addr=%h bc=%h pxd=%h, required all 0",
                     busy[0], done[0], read[0], pxv[0], addr[0], bc[0], pxd[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_line(0, 25'h0006000, 200, -1, 0, 0, pops, bad, dones, gaps, unst, wah, rah, fok);
        tests++;
        if (burst_addr.size() != 3 || burst_addr[0] !== 25'h0006000) begin
            fails++;
            $display("FAIL mid_restart_bursts: got %0d bursts first %h, required 3 first 0006000",
                     burst_addr.size(), burst_addr.size() > 0 ? burst_addr[0] : '0);
        end
        tests++;
        if (pops != 20 || bad != 0 || dones != 1) begin
            fails++;
            $display("FAIL mid_restart_data: got %0d pops %0d bad %0d done, required 20 0 1", pops, bad, dones);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            base[i]  = '0;
            wr[i]    = 1'b0;
            pxr[i]   = 1'b1;
        end
        test_reset();
        test_line20();
        test_backpressure();
        test_waitrequest();
        test_wrap();
        test_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
